// File: rtl/coms_pkg.sv
// coms_pkg: shared frame constants, lengths and state encodings for the motor
// communications engine.
package coms_pkg;
    localparam logic [31:0] MAGIC_STATUS   = 32'h1CE1CEBB;
    localparam logic [31:0] MAGIC_SETPOINT = 32'hD0D0D0D0;
    localparam logic [31:0] MAGIC_CONTROL  = 32'hBAADA555;
    localparam logic [31:0] MAGIC_REPLY    = 32'h1CEB00DA;
    localparam int          LEN_STATUS     = 7;
    localparam int          LEN_SETPOINT   = 12;
    localparam int          LEN_CONTROL    = 21;
    localparam logic [7:0]  BCAST          = 8'hFF;

    typedef enum logic [1:0] {HUNT, RX_PAYLOAD, CHECK, TX_STATUS} state_t;
    typedef enum logic [1:0] {F_STATUS, F_SETPOINT, F_CONTROL} frame_t;

    // Payload length excludes the 4 magic bytes and the 2 CRC bytes.
    function automatic logic [4:0] pay_len(frame_t f);
        return f == F_STATUS ? 5'(LEN_STATUS - 6) :
               f == F_SETPOINT ? 5'(LEN_SETPOINT - 6) : 5'(LEN_CONTROL - 6);
    endfunction
endpackage

// File: rtl/crc16_d8.sv
// crc16_d8: one-byte step of CRC-16 poly 0x8005, data MSB first.
module crc16_d8 (
    input  logic [7:0]  data,
    input  logic [15:0] crc,
    output logic [15:0] crc_next
);
    always_comb begin
        crc_next = crc;
        for (int i = 7; i >= 0; i--)
            crc_next = {crc_next[14:0], 1'b0} ^ ((crc_next[15] ^ data[i]) ? 16'h8005 : 16'h0000);
    end
endmodule

// File: rtl/motor_coms_engine.sv
// motor_coms_engine: framed register-write / status-reply engine for NUM_MOTORS channels.
// Define COMS_RX_TIMEOUT_EN to abandon frames stalled for TIMEOUT_CYCLES idle cycles.
module motor_coms_engine
    import coms_pkg::*;
#(
    parameter int NUM_MOTORS     = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic [7:0]               ID,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    output logic                     tx_valid,
    output logic [7:0]               tx_data,
    input  logic                     tx_ready,
    input  logic [32*NUM_MOTORS-1:0] position,
    input  logic [32*NUM_MOTORS-1:0] velocity,
    output logic [32*NUM_MOTORS-1:0] setpoint,
    output logic [32*NUM_MOTORS-1:0] Kp,
    output logic [32*NUM_MOTORS-1:0] Ki,
    output logic [32*NUM_MOTORS-1:0] Kd,
    output logic [8*NUM_MOTORS-1:0]  control_mode,
    output logic [NUM_MOTORS-1:0]    update,
    output logic                     frame_ok,
    output logic [15:0]              crc_err_cnt,
    output logic                     rx_timeout
);
    localparam int BODY = 5 + 9 * NUM_MOTORS;
    localparam int TXW  = $clog2(BODY + 2);

    state_t                state, state_nx;
    frame_t                kind;
    logic [31:0]           window, win_nx;
    logic [135:0]          rx_sr;
    logic [4:0]            rx_cnt;
    logic [15:0]           rx_crc, rx_crc_nx, tx_crc, tx_crc_nx;
    logic [8*BODY-1:0]     tx_sr;
    logic [72*NUM_MOTORS-1:0] body;
    logic [TXW-1:0]        tx_idx;
    logic [NUM_MOTORS-1:0] sel;
    logic [7:0]            rx_id, rx_motor;
    logic                  is_magic, rx_last, tx_last, crc_ok, write_ok, stat_ok, timeout;

    crc16_d8 u_rx_crc (.data(rx_data), .crc(rx_crc), .crc_next(rx_crc_nx));
    crc16_d8 u_tx_crc (.data(tx_data), .crc(tx_crc), .crc_next(tx_crc_nx));

    // The receive shift register ends with the CRC in [15:0]; payload fields sit above it.
    assign win_nx   = {window[23:0], rx_data};
    assign is_magic = win_nx inside {MAGIC_STATUS, MAGIC_SETPOINT, MAGIC_CONTROL};
    assign rx_id    = kind == F_STATUS ? rx_sr[23:16] : kind == F_SETPOINT ? rx_sr[63:56] : rx_sr[135:128];
    assign rx_motor = kind == F_SETPOINT ? rx_sr[55:48] : rx_sr[127:120];
    assign rx_last  = rx_valid && rx_cnt == pay_len(kind) + 5'd1;
    assign crc_ok   = rx_crc == rx_sr[15:0];
    assign write_ok = crc_ok && kind != F_STATUS && (rx_id == ID || rx_id == BCAST) && |sel;
    assign stat_ok  = crc_ok && kind == F_STATUS && rx_id == ID;
    assign tx_valid = state == TX_STATUS;
    assign tx_last  = tx_valid && tx_ready && tx_idx == TXW'(BODY + 1);
    assign tx_data  = !tx_valid ? 8'h00 : tx_idx < TXW'(BODY) ? tx_sr[8*BODY-1 -: 8] :
                      tx_idx == TXW'(BODY) ? tx_crc[15:8] : tx_crc[7:0];

    always_comb begin
        sel  = '0;
        body = '0;
        for (int m = 0; m < NUM_MOTORS; m++) begin
            sel[m] = rx_motor == BCAST || rx_motor == 8'(m);
            body[72*(NUM_MOTORS-1-m) +: 72] = {control_mode[8*m +: 8], position[32*m +: 32], velocity[32*m +: 32]};
        end
    end

`ifdef COMS_RX_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    logic [IW-1:0] idle;
    assign timeout = state == RX_PAYLOAD && !rx_valid && idle == IW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge CLK or posedge reset)
        if (reset) begin
            idle       <= '0;
            rx_timeout <= 1'b0;
        end else begin
            idle       <= (state != RX_PAYLOAD || rx_valid) ? '0 : idle + 1'b1;
            rx_timeout <= timeout;
        end
`else
    assign timeout    = 1'b0;
    assign rx_timeout = TIMEOUT_CYCLES < 0;
`endif

    always_ff @(posedge CLK or posedge reset)
        state <= reset ? HUNT : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            HUNT:       state_nx = rx_valid && is_magic ? RX_PAYLOAD : HUNT;
            RX_PAYLOAD: state_nx = timeout ? HUNT : rx_last ? CHECK : RX_PAYLOAD;
            CHECK:      state_nx = stat_ok ? TX_STATUS : HUNT;
            TX_STATUS:  state_nx = tx_last ? HUNT : TX_STATUS;
            default:    state_nx = HUNT;
        endcase
    end

    always_ff @(posedge CLK or posedge reset)
        if (reset) begin
            window       <= '0;
            kind         <= F_STATUS;
            rx_sr        <= '0;
            rx_cnt       <= '0;
            rx_crc       <= '0;
            tx_sr        <= '0;
            tx_idx       <= '0;
            tx_crc       <= '0;
            setpoint     <= '0;
            Kp           <= '0;
            Ki           <= '0;
            Kd           <= '0;
            control_mode <= '0;
            update       <= '0;
            frame_ok     <= 1'b0;
            crc_err_cnt  <= '0;
        end else begin
            update   <= '0;
            frame_ok <= 1'b0;
            if (state != HUNT && state_nx == HUNT)
                window <= '0;
            else if (state == HUNT && rx_valid)
                window <= win_nx;
            if (state == HUNT && rx_valid) begin
                kind   <= win_nx == MAGIC_STATUS ? F_STATUS : win_nx == MAGIC_SETPOINT ? F_SETPOINT : F_CONTROL;
                rx_cnt <= '0;
                rx_crc <= 16'hFFFF;
            end
            if (state == RX_PAYLOAD && rx_valid) begin
                rx_sr  <= {rx_sr[127:0], rx_data};
                rx_cnt <= rx_cnt + 5'd1;
                if (rx_cnt < pay_len(kind))
                    rx_crc <= rx_crc_nx;
            end
            if (state == CHECK) begin
                if (!crc_ok && crc_err_cnt != 16'hFFFF)
                    crc_err_cnt <= crc_err_cnt + 16'd1;
                frame_ok <= write_ok || stat_ok;
                if (write_ok)
                    update <= sel;
                for (int m = 0; m < NUM_MOTORS; m++)
                    if (write_ok && sel[m] && kind == F_SETPOINT)
                        setpoint[32*m +: 32] <= rx_sr[47:16];
                    else if (write_ok && sel[m]) begin
                        control_mode[8*m +: 8] <= rx_sr[119:112];
                        Kp[32*m +: 32]         <= rx_sr[111:80];
                        Ki[32*m +: 32]         <= rx_sr[79:48];
                        Kd[32*m +: 32]         <= rx_sr[47:16];
                    end
                if (stat_ok) begin
                    tx_sr  <= {MAGIC_REPLY, ID, body};
                    tx_idx <= '0;
                    tx_crc <= 16'hFFFF;
                end
            end
            // The reply CRC skips the magic and stops before its own two bytes.
            if (tx_valid && tx_ready) begin
                tx_sr  <= tx_sr << 8;
                tx_idx <= tx_idx + 1'b1;
                if (tx_idx >= TXW'(4) && tx_idx < TXW'(BODY))
                    tx_crc <= tx_crc_nx;
            end
        end
endmodule

// File: tb/tb_motor_coms_engine.sv
// tb_motor_coms_engine: directed checks of framing, CRC, writes, status replies and reset.
// Covers the COMS_RX_TIMEOUT_EN build as well as the default build.
module tb_motor_coms_engine;
    logic        CLK = 1'b0, reset = 1'b1;
    logic [7:0]  ID = 8'h03;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_valid, tx_ready = 1'b1;
    logic [7:0]  tx_data;
    logic [63:0] position = '0, velocity = '0;
    logic [63:0] setpoint, Kp, Ki, Kd;
    logic [15:0] control_mode;
    logic [1:0]  update;
    logic        frame_ok, rx_timeout;
    logic [15:0] crc_err_cnt;

    int          total = 0, passed = 0;
    int          ok_cnt = 0, to_cnt = 0, stab_err = 0, cyc = 0;
    bit          throttle = 0, stalled = 0;
    logic [7:0]  prev_d;
    logic [1:0]  upd_last = '0;
    logic [7:0]  txq[$], pl[$], exp_q[$];

    motor_coms_engine #(.NUM_MOTORS(2), .TIMEOUT_CYCLES(100)) dut (
        .CLK(CLK), .reset(reset), .ID(ID), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .position(position), .velocity(velocity), .setpoint(setpoint), .Kp(Kp), .Ki(Ki), .Kd(Kd),
        .control_mode(control_mode), .update(update), .frame_ok(frame_ok),
        .crc_err_cnt(crc_err_cnt), .rx_timeout(rx_timeout)
    );

    always #5 CLK = ~CLK;

    // tx_ready is set before sampling so it pairs with the byte offered at the next edge.
    initial forever begin
        @(negedge CLK);
        cyc++;
        tx_ready = throttle ? (cyc % 3 == 0) : 1'b1;
        if (tx_valid) begin
            if (stalled && tx_data !== prev_d) stab_err++;
            if (tx_ready) txq.push_back(tx_data);
        end
        stalled = tx_valid && !tx_ready;
        prev_d  = tx_data;
        if (frame_ok) begin
            ok_cnt++;
            upd_last = update;
        end
        if (rx_timeout) to_cnt++;
    end

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r = c;
        for (int i = 7; i >= 0; i--) begin
            logic fb = r[15] ^ d[i];
            r = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h8005;
        end
        return r;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge CLK);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] magic, input bit bad);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < 4; i++) send_byte(magic[31-8*i -: 8]);
        foreach (pl[i]) begin
            send_byte(pl[i]);
            c = crc_upd(c, pl[i]);
        end
        if (bad) c[0] = ~c[0];
        send_byte(c[15:8]);
        send_byte(c[7:0]);
    endtask

    task automatic build_reply(input logic [7:0] m0, input logic [7:0] m1);
        logic [15:0] c = 16'hFFFF;
        exp_q = {8'h1C, 8'hEB, 8'h00, 8'hDA, 8'h03};
        for (int m = 0; m < 2; m++) begin
            exp_q.push_back(m == 0 ? m0 : m1);
            for (int b = 3; b >= 0; b--) exp_q.push_back(position[32*m+8*b +: 8]);
            for (int b = 3; b >= 0; b--) exp_q.push_back(velocity[32*m+8*b +: 8]);
        end
        for (int i = 4; i < exp_q.size(); i++) c = crc_upd(c, exp_q[i]);
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[7:0]);
    endtask

    task automatic wait_reply(input int n);
        for (int i = 0; i < 400 && txq.size() < n; i++) @(negedge CLK);
        wait_cyc(6);
    endtask

    task automatic test_reset;
        wait_cyc(3);
        total++; if (tx_valid !== 1'b0) $display("FAIL rst_tx_valid: got %b want 0", tx_valid); else passed++;
        total++; if (crc_err_cnt !== 16'h0) $display("FAIL rst_crc_cnt: got %h want 0", crc_err_cnt); else passed++;
        total++; if ({setpoint, Kp, Ki, Kd} !== '0) $display("FAIL rst_regs: got %h want 0", {setpoint, Kp, Ki, Kd}); else passed++;
        total++; if ({control_mode, update, frame_ok, rx_timeout, tx_data} !== '0)
            $display("FAIL rst_misc: got %h want 0", {control_mode, update, frame_ok, rx_timeout, tx_data}); else passed++;
        reset = 1'b0;
        wait_cyc(2);
    endtask

    task automatic test_setpoint;
        int o = ok_cnt;
        txq = {};
        pl  = {8'h03, 8'h01, 8'h00, 8'h00, 8'h12, 8'h34};
        send_frame(32'hD0D0D0D0, 0);
        wait_cyc(4);
        total++; if (setpoint !== {32'h00001234, 32'h0}) $display("FAIL sp_write: got %h want %h", setpoint, {32'h00001234, 32'h0}); else passed++;
        total++; if (upd_last !== 2'b10) $display("FAIL sp_update: got %b want 10", upd_last); else passed++;
        total++; if (ok_cnt - o !== 1) $display("FAIL sp_frame_ok: got %0d want 1", ok_cnt - o); else passed++;
        total++; if (update !== 2'b00) $display("FAIL sp_update_pulse: got %b want 00", update); else passed++;
        total++; if (txq.size() !== 0) $display("FAIL sp_no_tx: got %0d want 0", txq.size()); else passed++;
        total++; if (crc_err_cnt !== 16'h0) $display("FAIL sp_crc_cnt: got %h want 0", crc_err_cnt); else passed++;
    endtask

    task automatic test_crc_error;
        int o = ok_cnt;
        pl = {8'h03, 8'h01, 8'h00, 8'h00, 8'h56, 8'h78};
        send_frame(32'hD0D0D0D0, 1);
        wait_cyc(4);
        total++; if (crc_err_cnt !== 16'h1) $display("FAIL crc_cnt: got %h want 1", crc_err_cnt); else passed++;
        total++; if (setpoint[63:32] !== 32'h1234) $display("FAIL crc_no_write: got %h want 1234", setpoint[63:32]); else passed++;
        total++; if (ok_cnt - o !== 0) $display("FAIL crc_frame_ok: got %0d want 0", ok_cnt - o); else passed++;
    endtask

    task automatic test_control_bcast;
        pl = {8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h30};
        send_frame(32'hBAADA555, 0);
        wait_cyc(4);
        total++; if (control_mode !== 16'h0202) $display("FAIL ctl_mode: got %h want 0202", control_mode); else passed++;
        total++; if ({Kp, Ki, Kd} !== {{2{32'h10}}, {2{32'h20}}, {2{32'h30}}}) $display("FAIL ctl_gains: got %h %h %h", Kp, Ki, Kd); else passed++;
        total++; if (upd_last !== 2'b11) $display("FAIL ctl_update: got %b want 11", upd_last); else passed++;
        total++; if (setpoint[63:32] !== 32'h1234) $display("FAIL ctl_sp_kept: got %h want 1234", setpoint[63:32]); else passed++;
    endtask

    task automatic test_discard;
        int o = ok_cnt;
        pl = {8'h03, 8'h05, 8'h00, 8'h00, 8'h99, 8'h99};
        send_frame(32'hD0D0D0D0, 0);
        pl = {8'h04, 8'h00, 8'h00, 8'h00, 8'h99, 8'h99};
        send_frame(32'hD0D0D0D0, 0);
        wait_cyc(4);
        total++; if (setpoint !== {32'h00001234, 32'h0}) $display("FAIL disc_regs: got %h", setpoint); else passed++;
        total++; if (ok_cnt - o !== 0) $display("FAIL disc_frame_ok: got %0d want 0", ok_cnt - o); else passed++;
        total++; if (crc_err_cnt !== 16'h1) $display("FAIL disc_crc_cnt: got %h want 1", crc_err_cnt); else passed++;
    endtask

    task automatic test_status;
        int o = ok_cnt, bad = 0;
        position = {32'h11223344, 32'hDEADBEEF};
        velocity = {32'h55667788, 32'h0BADF00D};
        build_reply(8'h02, 8'h02);
        throttle = 1;
        stab_err = 0;
        txq = {};
        pl  = {8'h03};
        send_frame(32'h1CE1CEBB, 0);
        wait_reply(25);
        throttle = 0;
        total++; if (txq.size() !== 25) $display("FAIL st_len: got %0d want 25", txq.size()); else passed++;
        if (txq.size() == 25) foreach (exp_q[i]) if (txq[i] !== exp_q[i]) bad++;
        total++; if (bad !== 0) $display("FAIL st_bytes: got %0d wrong bytes want 0", bad); else passed++;
        total++; if (txq.size() >= 10 && {txq[6], txq[7], txq[8], txq[9]} !== 32'hDEADBEEF) $display("FAIL st_pos0: got %h%h%h%h want DEADBEEF", txq[6], txq[7], txq[8], txq[9]); else passed++;
        total++; if (stab_err !== 0) $display("FAIL st_stable: got %0d changes while stalled want 0", stab_err); else passed++;
        total++; if (ok_cnt - o !== 1) $display("FAIL st_frame_ok: got %0d want 1", ok_cnt - o); else passed++;
        total++; if (tx_valid !== 1'b0) $display("FAIL st_tx_done: got %b want 0", tx_valid); else passed++;
    endtask

    task automatic test_garbage;
        int bad = 0;
        txq = {};
        send_byte(8'h1C);
        pl = {8'h03};
        send_frame(32'h1CE1CEBB, 0);
        wait_reply(25);
        total++; if (txq.size() !== 25) $display("FAIL gb_len: got %0d want 25", txq.size()); else passed++;
        if (txq.size() == 25) foreach (exp_q[i]) if (txq[i] !== exp_q[i]) bad++;
        total++; if (bad !== 0) $display("FAIL gb_bytes: got %0d wrong bytes want 0", bad); else passed++;
    endtask

    task automatic test_status_bcast;
        int o = ok_cnt;
        txq = {};
        pl  = {8'hFF};
        send_frame(32'h1CE1CEBB, 0);
        wait_cyc(40);
        total++; if (txq.size() !== 0) $display("FAIL stb_no_reply: got %0d bytes want 0", txq.size()); else passed++;
        total++; if (ok_cnt - o !== 0) $display("FAIL stb_frame_ok: got %0d want 0", ok_cnt - o); else passed++;
    endtask

    task automatic test_back_to_back;
        int o = ok_cnt;
        pl = {8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA};
        send_frame(32'hD0D0D0D0, 0);
        pl = {8'h03, 8'h01, 8'h07, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03};
        send_frame(32'hBAADA555, 0);
        wait_cyc(4);
        total++; if (ok_cnt - o !== 2) $display("FAIL b2b_frame_ok: got %0d want 2", ok_cnt - o); else passed++;
        total++; if (setpoint[31:0] !== 32'hAA) $display("FAIL b2b_sp0: got %h want AA", setpoint[31:0]); else passed++;
        total++; if (control_mode !== 16'h0702) $display("FAIL b2b_mode: got %h want 0702", control_mode); else passed++;
        total++; if ({Kp[63:32], Kp[31:0], Kd[63:32]} !== {32'h1, 32'h10, 32'h3}) $display("FAIL b2b_gains: got %h %h", Kp, Kd); else passed++;
        total++; if (upd_last !== 2'b10) $display("FAIL b2b_update: got %b want 10", upd_last); else passed++;
    endtask

    task automatic test_timeout;
        int o = to_cnt;
        logic [15:0] c = 16'hFFFF;
        pl = {8'h03, 8'h00, 8'h00, 8'h00, 8'hAB, 8'hCD};
        foreach (pl[i]) c = crc_upd(c, pl[i]);
        for (int i = 0; i < 4; i++) send_byte(8'hD0);
        send_byte(8'h03);
        send_byte(8'h00);
        wait_cyc(105);
`ifdef COMS_RX_TIMEOUT_EN
        total++; if (to_cnt - o !== 1) $display("FAIL to_pulse: got %0d want 1", to_cnt - o); else passed++;
        send_frame(32'hD0D0D0D0, 0);
`else
        total++; if (to_cnt - o !== 0) $display("FAIL to_disabled: got %0d want 0", to_cnt - o); else passed++;
        for (int i = 2; i < 6; i++) send_byte(pl[i]);
        send_byte(c[15:8]);
        send_byte(c[7:0]);
`endif
        wait_cyc(4);
        total++; if (setpoint[31:0] !== 32'hABCD) $display("FAIL to_next_frame: got %h want ABCD", setpoint[31:0]); else passed++;
        total++; if (crc_err_cnt !== 16'h1) $display("FAIL to_crc_cnt: got %h want 1", crc_err_cnt); else passed++;
    endtask

    task automatic test_reset_tx;
        throttle = 1;
        pl = {8'h03};
        send_frame(32'h1CE1CEBB, 0);
        for (int i = 0; i < 20 && !tx_valid; i++) @(negedge CLK);
        total++; if (tx_valid !== 1'b1) $display("FAIL rtx_started: got %b want 1", tx_valid); else passed++;
        wait_cyc(4);
        reset = 1'b1;
        #1;
        total++; if (tx_valid !== 1'b0) $display("FAIL rtx_valid_drop: got %b want 0", tx_valid); else passed++;
        wait_cyc(2);
        total++; if ({crc_err_cnt, control_mode} !== '0) $display("FAIL rtx_cnt_mode: got %h %h want 0", crc_err_cnt, control_mode); else passed++;
        total++; if ({setpoint, Kp, Ki, Kd} !== '0) $display("FAIL rtx_regs: got %h want 0", {setpoint, Kp, Ki, Kd}); else passed++;
        throttle = 0;
        reset = 1'b0;
        wait_cyc(2);
    endtask

    initial begin
        test_reset;
        test_setpoint;
        test_crc_error;
        test_control_bcast;
        test_discard;
        test_status;
        test_garbage;
        test_status_bcast;
        test_back_to_back;
        test_timeout;
        test_reset_tx;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/motor_coms_engine.md
MOTOR_COMS_ENGINE -- requirements
Module: motor_coms_engine

Interface
REQ-001 Parameter NUM_MOTORS, default 2, number of motor channels served (1..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, inter-byte timeout in CLK cycles.
REQ-003 CLK  in  1  system clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ID  in  8  board address.
REQ-006 rx_valid, rx_data  in  1, 8  received byte strobe (one cycle per byte) and data.
REQ-007 tx_valid, tx_data  out  1, 8  byte offered to the transmitter.
REQ-008 tx_ready  in  1  transmitter accepts the byte when tx_valid and tx_ready are both high.
REQ-009 position, velocity  in  32*NUM_MOTORS each  signed per-motor status; motor m occupies bits [32m+31:32m].
REQ-010 setpoint, Kp, Ki, Kd  out  32*NUM_MOTORS each  per-motor registers, same packing.
REQ-011 control_mode  out  8*NUM_MOTORS  per-motor mode.
REQ-012 update  out  NUM_MOTORS  one-cycle strobe per motor whose registers were written.
REQ-013 frame_ok, crc_err_cnt, rx_timeout  out  1, 16, 1  good-frame pulse, saturating CRC error count, timeout pulse.

Function
REQ-014 Frames: 4-byte magic (MSB first), payload, 2-byte CRC (MSB first); CRC covers payload only.
REQ-015 CRC: CRC-16 polynomial x^16+x^15+x^2+1, init 0xFFFF, byte-wise, data MSB first, no final XOR.
REQ-016 Status request: magic 0x1CE1CEBB, payload {ID}, total 7 bytes.
REQ-017 Setpoint: magic 0xD0D0D0D0, payload {ID, motor, setpoint[4]}, total 12 bytes.
REQ-018 Control: magic 0xBAADA555, payload {ID, motor, mode, Kp[4], Ki[4], Kd[4]}, total 21 bytes.
REQ-019 States: HUNT, RX_PAYLOAD, CHECK, TX_STATUS.
REQ-020 HUNT: each rx_valid shifts a 4-byte window; a magic match enters RX_PAYLOAD with the frame length latched and the CRC seeded to 0xFFFF.
REQ-021 RX_PAYLOAD: CRC updated on the same cycle as each accepted rx_valid byte, excluding the 2 CRC bytes; payload is not scanned for magic; after the last byte, enter CHECK.
REQ-022 CHECK, one cycle: CRC mismatch increments crc_err_cnt (saturates at 0xFFFF) and returns to HUNT.
REQ-023 Write frames are accepted when ID byte == ID or 0xFF; motor byte 0xFF writes all motors; motor byte < NUM_MOTORS writes that motor; any other motor byte discards the frame with no count and no pulse.
REQ-024 Accepted write: registers and update bits change on the cycle after CHECK; frame_ok pulses at the same time; no reply is sent; next state HUNT.
REQ-025 Status request with ID byte == ID: position, velocity and control_mode for all motors are snapshotted in CHECK; frame_ok pulses; next state TX_STATUS. ID 0xFF gets no reply.
REQ-026 Status reply: magic 0x1CEB00DA, ID, then per motor m ascending {mode, position[4], velocity[4]}, then CRC over bytes 4..end-2; length 7+9*NUM_MOTORS.
REQ-027 TX_STATUS: tx_valid held with a stable tx_data until the byte is accepted; the index advances on accept; HUNT follows acceptance of the last byte.
REQ-028 rx_valid bytes arriving in TX_STATUS are dropped (half-duplex), and the magic window is cleared on entry to HUNT.
REQ-029 Multi-byte fields are big-endian.

Reset
REQ-030 Reset returns state to HUNT and clears window, counters and snapshot.
REQ-031 On reset, all outputs go to 0, except Kp, Ki and Kd, which go to 0.
REQ-032 Reset asserted during TX_STATUS deasserts tx_valid immediately.

Configuration
REQ-033 Macro COMS_RX_TIMEOUT_EN.
REQ-034 With COMS_RX_TIMEOUT_EN defined: TIMEOUT_CYCLES consecutive cycles in RX_PAYLOAD without rx_valid return the block to HUNT and pulse rx_timeout for one cycle; the partial frame is discarded and not counted as a CRC error.
REQ-035 Without COMS_RX_TIMEOUT_EN: RX_PAYLOAD waits indefinitely, and rx_timeout is tied to 0.

Structure
REQ-036 Shared package coms_pkg holds the magic numbers, frame lengths, broadcast code 0xFF and the state enumeration.
REQ-037 The sub-module crc16_d8 (combinational next-CRC from data[7:0] and crc[15:0]) is instantiated once for RX and once for TX.

Verification
REQ-038 ID=3, setpoint frame {03,01,00,00,12,34}+good CRC -> setpoint[63:32]=0x00001234, update=2'b10, frame_ok pulse, no tx_valid.
REQ-039 Same frame with CRC LSB flipped -> registers unchanged, crc_err_cnt 0->1.
REQ-040 Control frame, ID 0xFF, motor 0xFF, mode 0x02, Kp=0x10 -> both motors mode=2, Kp=0x10, update=2'b11.
REQ-041 Status request ID=3, position[31:0]=0xDEADBEEF, tx_ready toggling every 3rd cycle -> 25 bytes emitted, byte 6..9 = DE AD BE EF, CRC matches model, tx_data stable while stalled.
REQ-042 Garbage 0x1C 0x1C 0xE1 0xCE 0xBB then valid request payload -> match at correct window, reply sent.
REQ-043 With COMS_RX_TIMEOUT_EN and TIMEOUT_CYCLES=100, setpoint magic + 2 bytes then 100 idle cycles -> rx_timeout pulse, HUNT, next full frame accepted.
